// File: rtl/score_keeper_if.sv
// score_keeper_if: frame/ball inputs and score/state outputs of the score path.
// Latency: n/a (wiring only). Backpressure: none; all signals are level or pulse, no handshake.
// Ports: master = physics/overlay side (drives frame_tick, ball_x/y, start);
//        slave  = score_keeper (drives scores, goal_pause, ball_reset, game_over, winner, time_left).
interface score_keeper_if;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       start;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       goal_pause;
  logic       ball_reset;
  logic       game_over;
  logic [1:0] winner;
  logic [6:0] time_left;

  modport master (
    output frame_tick, ball_x, ball_y, start,
    input  score_p1, score_p2, goal_pause, ball_reset, game_over, winner, time_left
  );

  modport slave (
    input  frame_tick, ball_x, ball_y, start,
    output score_p1, score_p2, goal_pause, ball_reset, game_over, winner, time_left
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: goal detection, score keeping and match sequencing (IDLE/PLAY/HOLD/OVER).
// Latency: one cycle from the frame_tick/start cycle to the registered outputs.
// Backpressure: none; goal_pause asks the physics block to freeze during hold/over.
// Ports: clk, rst_n (async active-low); sk (slave modport of score_keeper_if).
// Optional: define MATCH_TIMER_EN to build the match countdown (time_left, timeout -> OVER).
module score_keeper #(
  parameter int GOAL_L_X    = 40,
  parameter int GOAL_R_X    = 600,
  parameter int GOAL_TOP_Y  = 300,
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_FRAMES = 120,
  parameter int MATCH_SECS  = 90,
  parameter int FPS         = 60
) (
  input  logic          clk,
  input  logic          rst_n,
  score_keeper_if.slave sk
);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD, OVER} state_t;

  localparam logic [9:0] GOAL_L = 10'(GOAL_L_X);
  localparam logic [9:0] GOAL_R = 10'(GOAL_R_X);
  localparam logic [9:0] TOP_Y  = 10'(GOAL_TOP_Y);
  localparam logic [3:0] WIN    = 4'(WIN_SCORE);
  localparam logic [7:0] HOLD_N = 8'(HOLD_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
  logic [7:0] hold_q, hold_d;
  logic       start_q;
  logic       goal_pause_q, game_over_q, ball_reset_q;
  logic [1:0] winner_q, winner_d;
  logic       respawn;
  logic       start_rise, goal_l, goal_r;

  assign start_rise = sk.start && !start_q;
  assign goal_l     = (sk.ball_x < GOAL_L) && (sk.ball_y >= TOP_Y);
  assign goal_r     = (sk.ball_x > GOAL_R) && (sk.ball_y >= TOP_Y);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= 4'd9) ? 4'd9 : s + 4'd1;
  endfunction

`ifdef MATCH_TIMER_EN
  localparam logic [6:0] SECS_N = 7'(MATCH_SECS);
  localparam logic [7:0] FPS_M1 = 8'(FPS - 1);
  logic [6:0] time_left_q, time_left_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       timeout;
`endif

  always_comb begin
    state_d    = state_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    hold_d     = hold_q;
    respawn    = 1'b0;
`ifdef MATCH_TIMER_EN
    time_left_d = time_left_q;
    frame_cnt_d = frame_cnt_q;
    timeout     = 1'b0;
`endif
    if (start_rise) begin
      // A start edge restarts the match from any state.
      state_d    = PLAY;
      score_p1_d = 4'd0;
      score_p2_d = 4'd0;
      hold_d     = 8'd0;
      respawn    = 1'b1;
`ifdef MATCH_TIMER_EN
      time_left_d = SECS_N;
      frame_cnt_d = 8'd0;
`endif
    end else begin
      case (state_q)
        PLAY: begin
          if (sk.frame_tick) begin
`ifdef MATCH_TIMER_EN
            if (frame_cnt_q >= FPS_M1) begin
              frame_cnt_d = 8'd0;
              if (time_left_q != 7'd0) time_left_d = time_left_q - 7'd1;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
            timeout = (time_left_d == 7'd0);
`endif
            // Ball in both mouths at once is impossible geometrically; treat it as no goal.
            if (goal_l && !goal_r) score_p2_d = sat_inc(score_p2_q);
            if (goal_r && !goal_l) score_p1_d = sat_inc(score_p1_q);
            if (goal_l ^ goal_r) begin
              if (score_p1_d == WIN || score_p2_d == WIN) begin
                state_d = OVER;
              end else begin
                state_d = HOLD;
                hold_d  = HOLD_N;
              end
            end
`ifdef MATCH_TIMER_EN
            // Goal already applied above; the timeout just overrides the next state.
            if (timeout) state_d = OVER;
`endif
          end
        end
        HOLD: begin
          if (sk.frame_tick) begin
            if (hold_q <= 8'd1) begin
              hold_d  = 8'd0;
              state_d = PLAY;
              respawn = 1'b1;
            end else begin
              hold_d = hold_q - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    winner_d = 2'b00;
    if (state_d == OVER) begin
      if (score_p1_d > score_p2_d)      winner_d = 2'b01;
      else if (score_p1_d < score_p2_d) winner_d = 2'b10;
      else                              winner_d = 2'b11;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      score_p1_q   <= 4'd0;
      score_p2_q   <= 4'd0;
      hold_q       <= 8'd0;
      start_q      <= 1'b0;
      goal_pause_q <= 1'b0;
      game_over_q  <= 1'b0;
      ball_reset_q <= 1'b0;
      winner_q     <= 2'b00;
    end else begin
      state_q      <= state_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      hold_q       <= hold_d;
      start_q      <= sk.start;
      goal_pause_q <= (state_d == HOLD) || (state_d == OVER);
      game_over_q  <= (state_d == OVER);
      // Suppress back-to-back pulses (e.g. hold expiry followed by a start edge).
      ball_reset_q <= respawn && !ball_reset_q;
      winner_q     <= winner_d;
    end
  end

`ifdef MATCH_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_left_q <= 7'd0;
      frame_cnt_q <= 8'd0;
    end else begin
      time_left_q <= time_left_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign sk.time_left = time_left_q;
`else
  assign sk.time_left = 7'd0;
`endif

  assign sk.score_p1   = score_p1_q;
  assign sk.score_p2   = score_p2_q;
  assign sk.goal_pause = goal_pause_q;
  assign sk.ball_reset = ball_reset_q;
  assign sk.game_over  = game_over_q;
  assign sk.winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for score_keeper (default build, timer disabled).
// Latency: expects results one cycle after each driven cycle.
// Backpressure: none.
module tb_score_keeper;

  logic clk;
  logic rst_n;
  score_keeper_if sk ();

  score_keeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sk    (sk.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] p1;
    logic [3:0] p2;
    logic       pause;
    logic       over;
    logic [1:0] win;
    logic       brst;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input string tag, input int p1, input int p2,
                              input int pause, input int over, input int win, input int brst);
    exp_t e;
    e.tag = tag; e.p1 = 4'(p1); e.p2 = 4'(p2);
    e.pause = 1'(pause); e.over = 1'(over); e.win = 2'(win); e.brst = 1'(brst);
    return e;
  endfunction

  task automatic pop_cmp();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".p1"},    int'(sk.score_p1),   int'(e.p1));
    chk({e.tag, ".p2"},    int'(sk.score_p2),   int'(e.p2));
    chk({e.tag, ".pause"}, int'(sk.goal_pause), int'(e.pause));
    chk({e.tag, ".over"},  int'(sk.game_over),  int'(e.over));
    chk({e.tag, ".win"},   int'(sk.winner),     int'(e.win));
    chk({e.tag, ".brst"},  int'(sk.ball_reset), int'(e.brst));
    chk({e.tag, ".tleft"}, int'(sk.time_left),  0);
  endtask

  // One clock: drive at posedge+1, result sampled at the next posedge+1.
  task automatic step(input logic ft, input logic st, input int x, input int y, input exp_t e);
    exp_q.push_back(e);
    sk.frame_tick = ft;
    sk.start      = st;
    sk.ball_x     = 10'(x);
    sk.ball_y     = 10'(y);
    @(posedge clk); #1;
    sk.frame_tick = 1'b0;
    pop_cmp();
  endtask

  // A frame tick followed by one quiet cycle; the quiet cycle must show no ball_reset.
  task automatic frame(input int x, input int y, input exp_t e);
    exp_t q;
    step(1'b1, sk.start, x, y, e);
    q = e; q.tag = {e.tag, "_idle"}; q.brst = 1'b0;
    step(1'b0, sk.start, x, y, q);
  endtask

  // Runs n hold frames from a fresh goal; the last one releases the hold if fin.
  task automatic run_hold(input int p1, input int p2, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      if (fin && i == n - 1) frame(320, 240, mk("hold_end", p1, p2, 0, 0, 0, 1));
      else                   frame(320, 240, mk("hold", p1, p2, 1, 0, 0, 0));
    end
  endtask

  task automatic start_rise(input string tag);
    step(1'b0, 1'b0, 320, 240, mk({tag, "_lo"}, sk.score_p1, sk.score_p2,
         sk.goal_pause, sk.game_over, sk.winner, 0));
  endtask

  initial begin
    rst_n = 1'b0;
    sk.frame_tick = 1'b0; sk.start = 1'b0; sk.ball_x = 10'd320; sk.ball_y = 10'd240;
    #2;
    chk("rst.p1", int'(sk.score_p1), 0);
    chk("rst.p2", int'(sk.score_p2), 0);
    chk("rst.pause", int'(sk.goal_pause), 0);
    chk("rst.brst", int'(sk.ball_reset), 0);
    chk("rst.over", int'(sk.game_over), 0);
    chk("rst.win", int'(sk.winner), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // New match from IDLE.
    step(1'b0, 1'b1, 320, 240, mk("start", 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 320, 240, mk("start_after", 0, 0, 0, 0, 0, 0));

    // Left goal, then full hold.
    frame(20, 350, mk("goal_p2", 0, 1, 1, 0, 0, 0));
    run_hold(0, 1, 120, 1'b1);

    // Over the crossbar: no goal.
    for (int i = 0; i < 10; i++) frame(620, 200, mk("high_ball", 0, 1, 0, 0, 0, 0));

    // P1 to five goals.
    for (int g = 1; g <= 4; g++) begin
      frame(620, 350, mk("goal_p1", g, 1, 1, 0, 0, 0));
      run_hold(g, 1, 120, 1'b1);
    end
    frame(620, 350, mk("win_p1", 5, 1, 1, 1, 1, 0));
    frame(620, 350, mk("over_frozen", 5, 1, 1, 1, 1, 0));

    // New match from OVER.
    step(1'b0, 1'b1, 320, 240, mk("restart_over", 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 320, 240, mk("restart_over_n", 0, 0, 0, 0, 0, 0));

    // Boundary geometry.
    frame(40, 350, mk("x_eq_l", 0, 0, 0, 0, 0, 0));
    frame(600, 350, mk("x_eq_r", 0, 0, 0, 0, 0, 0));
    frame(39, 299, mk("y_below", 0, 0, 0, 0, 0, 0));
    frame(39, 300, mk("y_eq_top", 0, 1, 1, 0, 0, 0));

    // Start edge in HOLD restarts.
    run_hold(0, 1, 5, 1'b0);
    step(1'b0, 1'b1, 320, 240, mk("restart_hold", 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b0, 320, 240, mk("restart_hold_n", 0, 0, 0, 0, 0, 0));

    // Async reset mid-hold at counter 60.
    frame(601, 480, mk("goal_p1b", 1, 0, 1, 0, 0, 0));
    run_hold(1, 0, 60, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst.p1", int'(sk.score_p1), 0);
    chk("arst.p2", int'(sk.score_p2), 0);
    chk("arst.pause", int'(sk.goal_pause), 0);
    chk("arst.over", int'(sk.game_over), 0);
    chk("arst.brst", int'(sk.ball_reset), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(1'b0, 1'b0, 320, 240, mk("post_rst", 0, 0, 0, 0, 0, 0));
    step(1'b0, 1'b1, 320, 240, mk("start2", 0, 0, 0, 0, 0, 1));
    step(1'b0, 1'b1, 320, 240, mk("start2_n", 0, 0, 0, 0, 0, 0));
    frame(620, 350, mk("goal_p1c", 1, 0, 1, 0, 0, 0));

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
